// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment display readback path.
package disp_pkg;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [3:0] DIGIT_DASH    = 4'hE;
    localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } cap_state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational inverse of the digit-to-segment encoding; unknown patterns map to DIGIT_ILLEGAL.
module seg_decode
    import disp_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = DIGIT_ILLEGAL;
        case (seg_i)
            SEG_0:    digit_o = 4'd0;
            SEG_1:    digit_o = 4'd1;
            SEG_2:    digit_o = 4'd2;
            SEG_3:    digit_o = 4'd3;
            SEG_4:    digit_o = 4'd4;
            SEG_5:    digit_o = 4'd5;
            SEG_6:    digit_o = 4'd6;
            SEG_7:    digit_o = 4'd7;
            SEG_8:    digit_o = 4'd8;
            SEG_9:    digit_o = 4'd9;
            SEG_DASH: digit_o = DIGIT_DASH;
            default:  digit_o = DIGIT_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/disp_capture.sv
// Display-bus readback monitor: reconstructs four digits from multiplexed active-low an/seg lines.
// Define DISP_CAP_ERR_EN to enable the sticky per-digit illegal-pattern flags on err.
module disp_capture
    import disp_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] valid,
    output logic [3:0] err,
    output logic       frame
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SCNT_ONE = SW'(1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES);

    logic [10:0]   samp_q, samp_d, prev_q;
    cap_state_e    state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d, scnt_inc;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    d_q [4];
    logic [3:0]    d_d [4];
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    cap_q, cap_d;
    logic          frame_q, frame_d;

    logic [3:0] sel;
    logic       eligible;
    logic       same;
    logic [1:0] idx;
    logic [3:0] dec;
    logic       accept;
    logic       timeout_hit;

    assign samp_d   = {an, seg};
    assign sel      = ~samp_q[10:7];
    assign eligible = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign same     = (samp_q == prev_q);
    assign scnt_inc = scnt_q + SCNT_ONE;

    always_comb begin
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) idx = 2'(k);
        end
    end

    seg_decode u_seg_decode (
        .seg_i   (samp_q[6:0]),
        .digit_o (dec)
    );

    // Stability FSM; the accept fires on the sample that brings the count to STABLE_CYCLES.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        accept  = 1'b0;
        if (!eligible) begin
            state_d = IDLE;
            scnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    scnt_d  = SCNT_ONE;
                end
                SETTLE: begin
                    if (!same) begin
                        scnt_d = SCNT_ONE;
                    end else if (scnt_inc == SCNT_MAX) begin
                        state_d = HOLD;
                        scnt_d  = scnt_inc;
                        accept  = 1'b1;
                    end else begin
                        scnt_d = scnt_inc;
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state_d = SETTLE;
                        scnt_d  = SCNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    scnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        if (accept) begin
            tcnt_d = '0;
        end else if (tcnt_q != TCNT_MAX) begin
            tcnt_d = tcnt_q + TW'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
        timeout_hit = !accept && (tcnt_d == TCNT_MAX);
    end

    always_comb begin
        d_d     = d_q;
        valid_d = valid_q;
        cap_d   = cap_q;
        frame_d = 1'b0;
        // A completed set is reported and cleared before this cycle's accept is recorded.
        if (cap_q == 4'hF) begin
            frame_d = 1'b1;
            cap_d   = 4'd0;
        end
        if (accept) begin
            d_d[idx]     = dec;
            valid_d[idx] = 1'b1;
            cap_d[idx]   = 1'b1;
        end
        if (timeout_hit) begin
            valid_d = 4'd0;
            cap_d   = 4'd0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            samp_q  <= '1;
            prev_q  <= '1;
            state_q <= IDLE;
            scnt_q  <= '0;
            tcnt_q  <= '0;
            d_q     <= '{default: 4'h0};
            valid_q <= 4'd0;
            cap_q   <= 4'd0;
            frame_q <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            prev_q  <= samp_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            tcnt_q  <= tcnt_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            cap_q   <= cap_d;
            frame_q <= frame_d;
        end
    end

`ifdef DISP_CAP_ERR_EN
    logic [3:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && (dec == DIGIT_ILLEGAL)) err_d[idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 4'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 4'd0;
`endif

    assign d0    = d_q[0];
    assign d1    = d_q[1];
    assign d2    = d_q[2];
    assign d3    = d_q[3];
    assign valid = valid_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_disp_capture.sv
// Directed bench for disp_capture with an accept scoreboard keyed on expected visibility cycle.
module tb_disp_capture;

    localparam int S = 4;
    localparam int T = 1024;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] valid;
    logic [3:0] err;
    logic       frame;

    disp_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .an    (an),
        .seg   (seg),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .valid (valid),
        .err   (err),
        .frame (frame)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         due;
        int         k;
        logic [3:0] val;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  frame_cnt = 0;
    int  frame_first = -1;
    bit  watch7 = 1'b0;
    bit  seen7 = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dsel(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // Pops every scoreboard entry whose accept should be visible now.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            chk($sformatf("sb_d%0d@%0d", e.k, e.due), {28'd0, dsel(e.k)}, {28'd0, e.val});
            chk($sformatf("sb_valid%0d@%0d", e.k, e.due), {31'd0, valid[e.k]}, 32'd1);
        end
        if (frame) begin
            frame_cnt++;
            if (frame_first < 0) frame_first = cyc;
        end
        if (watch7 && d0 == 4'd7) seen7 = 1'b1;
    end

    task automatic present(input logic [3:0] a, input logic [6:0] s, input int hold,
                           input bit acc, input int k, input logic [3:0] v);
        an  = a;
        seg = s;
        if (acc) sb.push_back('{due: cyc + 1 + S, k: k, val: v});
        repeat (hold) @(negedge CLK);
    endtask

    logic [6:0] scan_seg [4];
    logic [3:0] scan_val [4];
    logic [3:0] err_ill;
    int         last_due;
    int         d3_due;

    initial begin
        scan_seg = '{7'b0110000, 7'b1111001, 7'b0011001, 7'b1111001};
        scan_val = '{4'd3, 4'd1, 4'd4, 4'd1};
`ifdef DISP_CAP_ERR_EN
        err_ill = 4'b0010;
`else
        err_ill = 4'b0000;
`endif
        RESET = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        repeat (3) @(negedge CLK);
        chk("rst_d", {16'd0, d3, d2, d1, d0}, 32'd0);
        chk("rst_valid", {28'd0, valid}, 32'd0);
        chk("rst_err", {28'd0, err}, 32'd0);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        RESET = 1'b1;

        // Idle, blank bus
        repeat (2000) @(negedge CLK);
        chk("idle_valid", {28'd0, valid}, 32'd0);
        chk("idle_frame_cnt", frame_cnt, 32'd0);
        chk("idle_d", {16'd0, d3, d2, d1, d0}, 32'd0);

        // Scan 3,1,4,1 with a one-cycle-early latency probe
        for (int k = 0; k < 4; k++) begin
            if (k == 3) d3_due = cyc + 1 + S;
            present(~(4'd1 << k), scan_seg[k], S, 1'b1, k, scan_val[k]);
            chk($sformatf("lat_early%0d", k), {31'd0, valid[k]}, 32'd0);
            repeat (8 - S) @(negedge CLK);
        end
        chk("scan_valid", {28'd0, valid}, 32'hF);
        chk("scan_frame_cnt", frame_cnt, 32'd1);
        chk("scan_frame_cyc", frame_first, d3_due + 1);

        // Glitch: 7 held S-1 cycles never lands, then 5 does
        watch7 = 1'b1;
        present(4'b1110, 7'b1111000, S - 1, 1'b0, 0, 4'd0);
        present(4'b1110, 7'b0010010, 6, 1'b1, 0, 4'd5);
        watch7 = 1'b0;
        chk("glitch_no7", {31'd0, seen7}, 32'd0);

        // Overlap: two anodes low is never eligible
        present(4'b1100, 7'b0000000, 20, 1'b0, 0, 4'd0);
        chk("overlap_valid", {28'd0, valid}, 32'hF);
        chk("overlap_d", {16'd0, d3, d2, d1, d0}, {16'd0, 4'd1, 4'd4, 4'd1, 4'd5});

        // Dash on digit 2, illegal on digit 1
        present(4'b1011, 7'b0111111, 8, 1'b1, 2, 4'hE);
        chk("dash_err", {28'd0, err}, 32'd0);
        present(4'b1101, 7'b1010101, 8, 1'b1, 1, 4'hF);
        chk("ill_err", {28'd0, err}, {28'd0, err_ill});

        // Reset mid-SETTLE, then re-present S-1 cycles: no accept may occur
        present(4'b1110, 7'b0000000, S - 1, 1'b0, 0, 4'd0);
        RESET = 1'b0;
        an    = 4'hF;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        present(4'b1110, 7'b0000000, S - 1, 1'b0, 0, 4'd0);
        present(4'hF, 7'h7F, 2 * S, 1'b0, 0, 4'd0);
        chk("midrst_valid", {28'd0, valid}, 32'd0);
        chk("midrst_d", {16'd0, d3, d2, d1, d0}, 32'd0);
        chk("midrst_err", {28'd0, err}, 32'd0);

        // Accept all four again, then let the bus go blank until timeout
        for (int k = 0; k < 4; k++) begin
            if (k == 3) last_due = cyc + 1 + S;
            present(~(4'd1 << k), scan_seg[k], 8, 1'b1, k, scan_val[k]);
        end
        an  = 4'hF;
        seg = 7'h7F;
        while (cyc < last_due + T - 1) @(negedge CLK);
        chk("to_before", {28'd0, valid}, 32'hF);
        @(negedge CLK);
        chk("to_at", {28'd0, valid}, 32'd0);
        chk("to_d_kept", {16'd0, d3, d2, d1, d0}, {16'd0, 4'd1, 4'd4, 4'd1, 4'd3});
        chk("frame_total", frame_cnt, 32'd2);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
